// File: rtl/encrypt.sv
// LWE encryption: sums the public-key rows picked by subset mod q, then adds plaintext*delta to entry 0.
// Ciphertext entries leave in row order, one per ct_valid/ct_ready handshake.
module encrypt #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 6,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 10,
  parameter int DIMENSION          = 1,
  parameter int BIG_N              = 30
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [PLAINTEXT_WIDTH-1:0]  plaintext,
  input  logic [BIG_N-1:0]            subset,
  input  logic [CIPHERTEXT_WIDTH-1:0] pk_entry,
  input  logic                        pk_valid,
  output logic                        pk_ready,
  output logic [CIPHERTEXT_WIDTH-1:0] ct_entry,
  output logic [DIMENSION:0]          ct_row,
  output logic                        ct_valid,
  input  logic                        ct_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int CW   = CIPHERTEXT_WIDTH;
  localparam int PW   = PLAINTEXT_WIDTH;
  localparam int NE   = DIMENSION + 1;
  localparam int ROWW = DIMENSION + 1;
  localparam int RW   = (BIG_N > 1) ? $clog2(BIG_N) : 1;
  localparam int EW   = (DIMENSION > 0) ? $clog2(DIMENSION + 1) : 1;
  localparam logic [CW-1:0] DELTA = CW'(CIPHERTEXT_MODULUS / PLAINTEXT_MODULUS);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} state_t;

  state_t            state_q;
  logic [PW-1:0]     pt_q;
  logic [BIG_N-1:0]  subset_q;
  logic [CW-1:0]     acc_q [NE];
  logic [CW-1:0]     acc_d [NE];
  logic [RW-1:0]     row_cnt_q;
  logic [EW-1:0]     entry_cnt_q;
  logic [EW-1:0]     k_q;
  logic [EW-1:0]     k_d;
  logic              pk_ready_q;
  logic              ct_valid_q;
  logic [CW-1:0]     ct_entry_q;
  logic [ROWW-1:0]   ct_row_q;
  logic              busy_q;
  logic              done_q;

  logic              pk_beat;
  logic              last_entry;
  logic              last_beat;
  logic [CW-1:0]     pt_ext;
  logic [CW-1:0]     m_delta;

  assign pk_beat    = (state_q == ACCUM) && pk_valid && pk_ready_q;
  assign last_entry = (entry_cnt_q == EW'(DIMENSION));
  assign last_beat  = pk_beat && last_entry && (row_cnt_q == RW'(BIG_N - 1));
  assign pt_ext     = {{(CW-PW){1'b0}}, pt_q};
  assign m_delta    = pt_ext * DELTA;
  assign k_d        = k_q + EW'(1);

  // Next accumulator image; the message term is folded into entry 0 on the final beat.
  always_comb begin
    acc_d = acc_q;
    if (pk_beat && subset_q[row_cnt_q]) begin
      acc_d[entry_cnt_q] = acc_q[entry_cnt_q] + pk_entry;
    end
    if (last_beat) begin
      acc_d[0] = acc_d[0] + m_delta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pt_q        <= '0;
      subset_q    <= '0;
      for (int i = 0; i < NE; i++) acc_q[i] <= '0;
      row_cnt_q   <= '0;
      entry_cnt_q <= '0;
      k_q         <= '0;
      pk_ready_q  <= 1'b0;
      ct_valid_q  <= 1'b0;
      ct_entry_q  <= '0;
      ct_row_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pt_q        <= plaintext;
            subset_q    <= subset;
            for (int i = 0; i < NE; i++) acc_q[i] <= '0;
            row_cnt_q   <= '0;
            entry_cnt_q <= '0;
            k_q         <= '0;
            pk_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ACCUM;
          end
        end
        ACCUM: begin
          if (pk_beat) begin
            acc_q <= acc_d;
            if (last_entry) begin
              entry_cnt_q <= '0;
              row_cnt_q   <= row_cnt_q + RW'(1);
            end else begin
              entry_cnt_q <= entry_cnt_q + EW'(1);
            end
            if (last_beat) begin
              row_cnt_q  <= '0;
              pk_ready_q <= 1'b0;
              ct_valid_q <= 1'b1;
              ct_entry_q <= acc_d[0];
              ct_row_q   <= '0;
              k_q        <= '0;
              state_q    <= EMIT;
            end
          end
        end
        EMIT: begin
          // Presented entry only moves on a completed handshake.
          if (ct_ready) begin
            if (k_q == EW'(DIMENSION)) begin
              ct_valid_q <= 1'b0;
              ct_entry_q <= '0;
              ct_row_q   <= '0;
              k_q        <= '0;
              done_q     <= 1'b1;
              state_q    <= DONE;
            end else begin
              k_q        <= k_d;
              ct_row_q   <= ROWW'(k_d);
              ct_entry_q <= acc_q[k_d];
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pk_ready = pk_ready_q;
  assign ct_valid = ct_valid_q;
  assign ct_entry = ct_entry_q;
  assign ct_row   = ct_row_q;
  assign busy     = busy_q;
  assign done     = done_q;

  assert property (@(posedge clk) disable iff (!rst_n)
    ct_valid_q && !ct_ready |=> ct_valid_q && $stable(ct_entry_q) && $stable(ct_row_q));
  assert property (@(posedge clk) disable iff (!rst_n) done_q |=> !done_q);

endmodule
